setpoint_menu: RTL and testbench

- Three-button setpoint editor for the greenhouse controller.
- Consumes one-cycle click pulses from the per-button debouncers (UP, DOWN, SELECT).
- Sequences an edit menu: temperature, then humidity, then commit.
- Holds the committed temperature and humidity setpoints used by the climate-control logic; drives the display value and mode.

---
 rtl/setpoint_pkg.sv | 52 +++++
 rtl/setpoint_menu_hold_repeat.sv | 46 ++++
 rtl/setpoint_menu.sv | 184 ++++++++++++++++++
 tb/tb_setpoint_menu.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/setpoint_pkg.sv
// Shared types and constants for the greenhouse setpoint editor, plus the
// saturating step used for every UP/DOWN edit.
package setpoint_pkg;

    localparam int SP_W = 8;

    typedef logic [SP_W-1:0] sp_t;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_EDIT_TEMP = 2'd1,
        ST_EDIT_HUM  = 2'd2,
        ST_COMMIT    = 2'd3
    } state_e;

    localparam sp_t TEMP_DEF_C = 8'd72;
    localparam sp_t HUM_DEF_C  = 8'd60;
    localparam sp_t TEMP_MIN_C = 8'd50;
    localparam sp_t TEMP_MAX_C = 8'd95;
    localparam sp_t HUM_MIN_C  = 8'd20;
    localparam sp_t HUM_MAX_C  = 8'd90;

    localparam logic [31:0] TIMEOUT_CYC_C  = 32'd500_000_000;
    localparam logic [31:0] REPEAT_DELAY_C = 32'd50_000_000;
    localparam logic [31:0] REPEAT_RATE_C  = 32'd10_000_000;

    // One step is taken in SP_W+1 bits so the carry/borrow shows up in the MSB
    // instead of wrapping; the result is then clamped into [lo, hi].
    function automatic sp_t sat_step(input sp_t val, input logic inc, input logic dec,
                                     input sp_t lo, input sp_t hi);
        logic [SP_W:0] t;
        t = {1'b0, val};
        if (inc && !dec) begin
            t = t + (SP_W+1)'(1);
        end else if (dec && !inc) begin
            t = t - (SP_W+1)'(1);
        end else begin
            return val;
        end
        if (t[SP_W]) begin
            t = inc ? {1'b0, hi} : {1'b0, lo};
        end
        if (t > {1'b0, hi}) begin
            t = {1'b0, hi};
        end
        if (t < {1'b0, lo}) begin
            t = {1'b0, lo};
        end
        return t[SP_W-1:0];
    endfunction

endpackage

// File: rtl/setpoint_menu_hold_repeat.sv
// Auto-repeat generator: a level held for REPEAT_DELAY cycles yields a step,
// then one more step every REPEAT_RATE cycles until the level drops.
module hold_repeat #(
    parameter logic [31:0] REPEAT_DELAY = 32'd50_000_000,
    parameter logic [31:0] REPEAT_RATE  = 32'd10_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic level_i,
    output logic step_o
);

    logic [31:0] cnt_q, cnt_d;
    logic        rep_q, rep_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            rep_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            rep_q <= rep_d;
        end
    end

    // rep_q selects between the initial hold delay and the repeat period.
    always_comb begin
        cnt_d  = cnt_q;
        rep_d  = rep_q;
        step_o = 1'b0;
        if (!level_i) begin
            cnt_d = '0;
            rep_d = 1'b0;
        end else if (!rep_q && cnt_q == REPEAT_DELAY - 32'd1) begin
            step_o = 1'b1;
            cnt_d  = '0;
            rep_d  = 1'b1;
        end else if (rep_q && cnt_q == REPEAT_RATE - 32'd1) begin
            step_o = 1'b1;
            cnt_d  = '0;
        end else begin
            cnt_d = cnt_q + 32'd1;
        end
    end

endmodule

// File: rtl/setpoint_menu.sv
// Three-button setpoint editor: IDLE -> EDIT_TEMP -> EDIT_HUM -> COMMIT.
// Define SETPOINT_AUTOREPEAT_EN to add hold-to-repeat on up_level/dn_level.
module setpoint_menu
    import setpoint_pkg::*;
#(
    parameter sp_t         TEMP_DEF     = TEMP_DEF_C,
    parameter sp_t         HUM_DEF      = HUM_DEF_C,
    parameter sp_t         TEMP_MIN     = TEMP_MIN_C,
    parameter sp_t         TEMP_MAX     = TEMP_MAX_C,
    parameter sp_t         HUM_MIN      = HUM_MIN_C,
    parameter sp_t         HUM_MAX      = HUM_MAX_C,
    parameter logic [31:0] TIMEOUT_CYC  = TIMEOUT_CYC_C,
    parameter logic [31:0] REPEAT_DELAY = REPEAT_DELAY_C,
    parameter logic [31:0] REPEAT_RATE  = REPEAT_RATE_C
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            up_click,
    input  logic            dn_click,
    input  logic            sel_click,
    input  logic            up_level,
    input  logic            dn_level,
    output logic [SP_W-1:0] temp_sp,
    output logic [SP_W-1:0] hum_sp,
    output logic [SP_W-1:0] edit_val,
    output logic [1:0]      mode,
    output logic            sp_update
);

    state_e      state_q, state_d;
    sp_t         edit_q, edit_d;
    sp_t         temp_q, temp_d;
    sp_t         hum_q, hum_d;
    sp_t         stg_temp_q, stg_temp_d;
    sp_t         stg_hum_q, stg_hum_d;
    logic [31:0] tmo_q, tmo_d;
    logic        upd_q, upd_d;

    logic in_edit;
    logic up_rep, dn_rep;
    logic up_ev, dn_ev, any_click, expire;

    assign in_edit = (state_q == ST_EDIT_TEMP) || (state_q == ST_EDIT_HUM);

`ifdef SETPOINT_AUTOREPEAT_EN
    logic up_hold, dn_hold;

    // Holding both buttons is treated as no intent, so neither side repeats.
    assign up_hold = up_level && !dn_level && in_edit;
    assign dn_hold = dn_level && !up_level && in_edit;

    hold_repeat #(
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_RATE  (REPEAT_RATE)
    ) u_up_repeat (
        .clk     (clk),
        .rst_n   (rst_n),
        .level_i (up_hold),
        .step_o  (up_rep)
    );

    hold_repeat #(
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_RATE  (REPEAT_RATE)
    ) u_dn_repeat (
        .clk     (clk),
        .rst_n   (rst_n),
        .level_i (dn_hold),
        .step_o  (dn_rep)
    );
`else
    logic [65:0] unused_repeat;
    assign unused_repeat = {up_level, dn_level, REPEAT_DELAY, REPEAT_RATE};
    assign up_rep = 1'b0;
    assign dn_rep = 1'b0;
`endif

    assign up_ev     = up_click || up_rep;
    assign dn_ev     = dn_click || dn_rep;
    assign any_click = up_ev || dn_ev || sel_click;
    assign expire    = in_edit && (tmo_q == TIMEOUT_CYC - 32'd1) && !any_click;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            edit_q     <= '0;
            temp_q     <= TEMP_DEF;
            hum_q      <= HUM_DEF;
            stg_temp_q <= '0;
            stg_hum_q  <= '0;
            tmo_q      <= '0;
            upd_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            edit_q     <= edit_d;
            temp_q     <= temp_d;
            hum_q      <= hum_d;
            stg_temp_q <= stg_temp_d;
            stg_hum_q  <= stg_hum_d;
            tmo_q      <= tmo_d;
            upd_q      <= upd_d;
        end
    end

    // Next state and idle-timeout counter; sel outranks the timeout.
    always_comb begin
        state_d = state_q;
        tmo_d   = '0;
        case (state_q)
            ST_IDLE: begin
                if (sel_click) state_d = ST_EDIT_TEMP;
            end
            ST_EDIT_TEMP, ST_EDIT_HUM: begin
                tmo_d = any_click ? 32'd0 : tmo_q + 32'd1;
                if (sel_click) begin
                    state_d = (state_q == ST_EDIT_TEMP) ? ST_EDIT_HUM : ST_COMMIT;
                end else if (expire) begin
                    state_d = ST_IDLE;
                    tmo_d   = '0;
                end
            end
            ST_COMMIT: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Datapath updates for edit value, staging and committed setpoints.
    always_comb begin
        edit_d     = edit_q;
        temp_d     = temp_q;
        hum_d      = hum_q;
        stg_temp_d = stg_temp_q;
        stg_hum_d  = stg_hum_q;
        upd_d      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (sel_click) edit_d = temp_q;
            end
            ST_EDIT_TEMP: begin
                if (sel_click) begin
                    stg_temp_d = edit_q;
                    edit_d     = hum_q;
                end else if (expire) begin
                    edit_d     = '0;
                    stg_temp_d = '0;
                    stg_hum_d  = '0;
                end else begin
                    edit_d = sat_step(edit_q, up_ev, dn_ev, TEMP_MIN, TEMP_MAX);
                end
            end
            ST_EDIT_HUM: begin
                if (sel_click) begin
                    stg_hum_d = edit_q;
                end else if (expire) begin
                    edit_d     = '0;
                    stg_temp_d = '0;
                    stg_hum_d  = '0;
                end else begin
                    edit_d = sat_step(edit_q, up_ev, dn_ev, HUM_MIN, HUM_MAX);
                end
            end
            ST_COMMIT: begin
                temp_d = stg_temp_q;
                hum_d  = stg_hum_q;
                upd_d  = 1'b1;
                edit_d = '0;
            end
            default: begin
                edit_d = '0;
            end
        endcase
    end

    assign temp_sp   = temp_q;
    assign hum_sp    = hum_q;
    assign edit_val  = edit_q;
    assign mode      = state_q;
    assign sp_update = upd_q;

endmodule

// File: tb/tb_setpoint_menu.sv
// Directed, table-driven bench for setpoint_menu with shortened timers.
module tb_setpoint_menu;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       up_click = 1'b0, dn_click = 1'b0, sel_click = 1'b0;
    logic       up_level = 1'b0, dn_level = 1'b0;
    logic [7:0] temp_sp, hum_sp, edit_val;
    logic [1:0] mode;
    logic       sp_update;

    int n_vec = 0;
    int n_bad = 0;

    setpoint_menu #(
        .TIMEOUT_CYC  (32'd100),
        .REPEAT_DELAY (32'd20),
        .REPEAT_RATE  (32'd5)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .up_click  (up_click),
        .dn_click  (dn_click),
        .sel_click (sel_click),
        .up_level  (up_level),
        .dn_level  (dn_level),
        .temp_sp   (temp_sp),
        .hum_sp    (hum_sp),
        .edit_val  (edit_val),
        .mode      (mode),
        .sp_update (sp_update)
    );

    always #5 clk = ~clk;

    typedef struct {
        string name;
        int    rep;
        bit    rst, up, dn, sel;
        int    mode, edit, temp, hum;
        bit    upd;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input string nm, input int rep, input bit rst, input bit up,
                       input bit dn, input bit sel, input int m, input int e,
                       input int t, input int h, input bit u);
        vec_t v;
        v.name = nm; v.rep = rep; v.rst = rst; v.up = up; v.dn = dn; v.sel = sel;
        v.mode = m; v.edit = e; v.temp = t; v.hum = h; v.upd = u;
        vecs.push_back(v);
    endtask

    task automatic check(input string nm, input int m, input int e, input int t,
                         input int h, input bit u);
        logic [26:0] act, exp;
        act = {mode, edit_val, temp_sp, hum_sp, sp_update};
        exp = {m[1:0], e[7:0], t[7:0], h[7:0], u};
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got mode=%0d edit=%0d temp=%0d hum=%0d upd=%0d, want mode=%0d edit=%0d temp=%0d hum=%0d upd=%0d",
                     nm, mode, edit_val, temp_sp, hum_sp, sp_update, m, e, t, h, u);
        end
    endtask

    task automatic click(input bit up, input bit dn, input bit sel);
        @(negedge clk);
        up_click = up; dn_click = dn; sel_click = sel;
        @(negedge clk);
        up_click = 1'b0; dn_click = 1'b0; sel_click = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        //   name            rep rst up dn sel  mode edit temp hum upd
        add("reset",          1, 1, 0, 0, 0,   0,   0,  72, 60, 0);
        add("idle_up",        1, 0, 1, 0, 0,   0,   0,  72, 60, 0);
        add("idle_dn",        1, 0, 0, 1, 0,   0,   0,  72, 60, 0);
        add("sel_temp",       1, 0, 0, 0, 1,   1,  72,  72, 60, 0);
        add("up1",            1, 0, 1, 0, 0,   1,  73,  72, 60, 0);
        add("up2",            1, 0, 1, 0, 0,   1,  74,  72, 60, 0);
        add("up3",            1, 0, 1, 0, 0,   1,  75,  72, 60, 0);
        add("sel_hum",        1, 0, 0, 0, 1,   2,  60,  72, 60, 0);
        add("dn1",            1, 0, 0, 1, 0,   2,  59,  72, 60, 0);
        add("dn2",            1, 0, 0, 1, 0,   2,  58,  72, 60, 0);
        add("sel_commit",     1, 0, 0, 0, 1,   3,  58,  72, 60, 0);
        add("commit_ignore",  1, 0, 1, 1, 1,   0,   0,  75, 58, 1);
        add("upd_one_cycle",  1, 0, 0, 0, 0,   0,   0,  75, 58, 0);
        // saturation at both ends
        add("sat_reset",      1, 1, 0, 0, 0,   0,   0,  72, 60, 0);
        add("sat_sel",        1, 0, 0, 0, 1,   1,  72,  72, 60, 0);
        add("sat_up30",      30, 0, 1, 0, 0,   1,  95,  72, 60, 0);
        add("sat_sel_hum",    1, 0, 0, 0, 1,   2,  60,  72, 60, 0);
        add("sat_dn50",      50, 0, 0, 1, 0,   2,  20,  72, 60, 0);
        add("sat_sel_commit", 1, 0, 0, 0, 1,   3,  20,  72, 60, 0);
        add("sat_commit",     1, 0, 0, 0, 0,   0,   0,  95, 20, 1);
        // timeout expires after exactly 100 idle cycles
        add("to_reset",       1, 1, 0, 0, 0,   0,   0,  72, 60, 0);
        add("to_sel",         1, 0, 0, 0, 1,   1,  72,  72, 60, 0);
        add("to_up1",         1, 0, 1, 0, 0,   1,  73,  72, 60, 0);
        add("to_up2",         1, 0, 1, 0, 0,   1,  74,  72, 60, 0);
        add("to_idle99",     99, 0, 0, 0, 0,   1,  74,  72, 60, 0);
        add("to_expire",      1, 0, 0, 0, 0,   0,   0,  72, 60, 0);
        add("to_no_upd",      1, 0, 0, 0, 0,   0,   0,  72, 60, 0);
        // click in the expiry cycle keeps the edit alive
        add("tc_sel",         1, 0, 0, 0, 1,   1,  72,  72, 60, 0);
        add("tc_up",          1, 0, 1, 0, 0,   1,  73,  72, 60, 0);
        add("tc_idle99",     99, 0, 0, 0, 0,   1,  73,  72, 60, 0);
        add("tc_dn_expiry",   1, 0, 0, 1, 0,   1,  72,  72, 60, 0);
        add("tc_idle99b",    99, 0, 0, 0, 0,   1,  72,  72, 60, 0);
        add("tc_expire",      1, 0, 0, 0, 0,   0,   0,  72, 60, 0);
        // simultaneous clicks
        add("si_reset",       1, 1, 0, 0, 0,   0,   0,  72, 60, 0);
        add("si_sel",         1, 0, 0, 0, 1,   1,  72,  72, 60, 0);
        add("si_up",          1, 0, 1, 0, 0,   1,  73,  72, 60, 0);
        add("si_sel_up",      1, 0, 1, 0, 1,   2,  60,  72, 60, 0);
        add("si_up_dn",       1, 0, 1, 1, 0,   2,  60,  72, 60, 0);
        add("si_idle99",     99, 0, 0, 0, 0,   2,  60,  72, 60, 0);
        add("si_up_dn_tmo",   1, 0, 1, 1, 0,   2,  60,  72, 60, 0);
        add("si_idle99b",    99, 0, 0, 0, 0,   2,  60,  72, 60, 0);
        add("si_sel_commit",  1, 0, 0, 0, 1,   3,  60,  72, 60, 0);
        add("si_commit",      1, 0, 0, 0, 0,   0,   0,  73, 60, 1);

        foreach (vecs[i]) begin
            for (int k = 0; k < vecs[i].rep; k++) begin
                @(negedge clk);
                rst_n     = !vecs[i].rst;
                up_click  = vecs[i].up;
                dn_click  = vecs[i].dn;
                sel_click = vecs[i].sel;
                @(posedge clk);
                #1;
            end
            check(vecs[i].name, vecs[i].mode, vecs[i].edit, vecs[i].temp,
                  vecs[i].hum, vecs[i].upd);
        end
        @(negedge clk);
        rst_n = 1'b1; up_click = 1'b0; dn_click = 1'b0; sel_click = 1'b0;

        // Asynchronous reset in the middle of EDIT_HUM
        click(0, 0, 1);
        click(0, 0, 1);
        click(1, 0, 0);
        check("ar_before", 2, 61, 73, 60, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_immediate", 0, 0, 72, 60, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("ar_no_update", 0, 0, 72, 60, 0);

        // Held UP level in EDIT_TEMP
        do_reset();
        click(0, 0, 1);
        up_level = 1'b1;
        repeat (45) @(posedge clk);
        #1;
`ifdef SETPOINT_AUTOREPEAT_EN
        check("hold_up45", 1, 78, 72, 60, 0);
`else
        check("hold_up45", 1, 72, 72, 60, 0);
`endif
        @(negedge clk);
        up_level = 1'b1;
        dn_level = 1'b1;
        repeat (30) @(posedge clk);
        #1;
`ifdef SETPOINT_AUTOREPEAT_EN
        check("hold_both", 1, 78, 72, 60, 0);
`else
        check("hold_both", 1, 72, 72, 60, 0);
`endif
        @(negedge clk);
        up_level = 1'b0;
        dn_level = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
